// File: rtl/ahb_refill_master.sv
// AHB-Lite read manager that fetches one I-cache line as a fixed-length INCR burst.
// Each returned word is handed back with its line index; done/err close the refill.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a refill request (req_ready high after cooldown)
// ADDR  | first beat address phase, htrans=NONSEQ
// BURST | address phase N+1 overlapping data phase N
// LAST  | data phase of the final beat, htrans=IDLE
// ERR   | second cycle of an ERROR response
module ahb_refill_master #(
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [31:0]      req_addr,
   output logic             req_ready,
   output logic             beat_valid,
   output logic [31:0]      beat_data,
   output logic [IDX_W-1:0] beat_idx,
   output logic             done,
   output logic             err,
   output logic [31:0]      haddr,
   output logic [1:0]       htrans,
   output logic [2:0]       hburst,
   output logic [2:0]       hsize,
   output logic             hwrite,
   input  logic [31:0]      hrdata,
   input  logic             hready,
   input  logic             hresp
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_BURST = 3'd2,
      S_LAST  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [31:0]      LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [2:0]       HBURST_C  = (LINE_WORDS == 16) ? 3'b111 :
                                            (LINE_WORDS == 8)  ? 3'b101 : 3'b011;
   localparam logic [1:0]       TR_IDLE   = 2'b00;
   localparam logic [1:0]       TR_NONSEQ = 2'b10;
   localparam logic [1:0]       TR_SEQ    = 2'b11;

   state_t           state_q, state_d;
   logic [31:0]      haddr_q, haddr_d;
   logic [1:0]       htrans_q, htrans_d;
   logic [IDX_W-1:0] a_idx_q, a_idx_d;
   logic [IDX_W-1:0] d_idx_q, d_idx_d;
   logic             req_ready_q, req_ready_d;
   logic             beat_valid_q, beat_valid_d;
   logic [31:0]      beat_data_q, beat_data_d;
   logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             accept;
   logic             capture;
   logic             term_err;

   assign accept = req_valid && req_ready_q;

   always_comb begin
      state_d      = state_q;
      haddr_d      = haddr_q;
      htrans_d     = htrans_q;
      a_idx_d      = a_idx_q;
      d_idx_d      = d_idx_q;
      req_ready_d  = 1'b0;
      beat_valid_d = 1'b0;
      beat_data_d  = beat_data_q;
      beat_idx_d   = beat_idx_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      capture      = 1'b0;
      term_err     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // req_ready stays low for the cycle right after done
            req_ready_d = !accept;
            if (accept) begin
               haddr_d  = req_addr & LINE_MASK;
               htrans_d = TR_NONSEQ;
               a_idx_d  = '0;
               d_idx_d  = '0;
               state_d  = S_ADDR;
            end
         end
         S_ADDR: begin
            if (hready) begin
               haddr_d  = haddr_q + 32'd4;
               htrans_d = TR_SEQ;
               a_idx_d  = a_idx_q + IDX_ONE;
               state_d  = S_BURST;
            end
         end
         S_BURST: begin
            if (hready && hresp) begin
               term_err = 1'b1;
            end else if (hresp) begin
               htrans_d = TR_IDLE;
               state_d  = S_ERR;
            end else if (hready) begin
               capture = 1'b1;
               if (a_idx_q == LAST_IDX) begin
                  htrans_d = TR_IDLE;
                  state_d  = S_LAST;
               end else begin
                  haddr_d  = haddr_q + 32'd4;
                  htrans_d = TR_SEQ;
                  a_idx_d  = a_idx_q + IDX_ONE;
               end
            end
         end
         S_LAST: begin
            if (hready && hresp) begin
               term_err = 1'b1;
            end else if (hresp) begin
               state_d = S_ERR;
            end else if (hready) begin
               capture = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            if (hready) begin
               term_err = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            htrans_d = TR_IDLE;
         end
      endcase

      if (capture) begin
         beat_valid_d = 1'b1;
         beat_data_d  = hrdata;
         beat_idx_d   = d_idx_q;
         d_idx_d      = d_idx_q + IDX_ONE;
         done_d       = (d_idx_q == LAST_IDX);
      end

      if (term_err) begin
         done_d   = 1'b1;
         err_d    = 1'b1;
         htrans_d = TR_IDLE;
         state_d  = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         haddr_q      <= '0;
         htrans_q     <= TR_IDLE;
         a_idx_q      <= '0;
         d_idx_q      <= '0;
         req_ready_q  <= 1'b1;
         beat_valid_q <= 1'b0;
         beat_data_q  <= '0;
         beat_idx_q   <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         haddr_q      <= haddr_d;
         htrans_q     <= htrans_d;
         a_idx_q      <= a_idx_d;
         d_idx_q      <= d_idx_d;
         req_ready_q  <= req_ready_d;
         beat_valid_q <= beat_valid_d;
         beat_data_q  <= beat_data_d;
         beat_idx_q   <= beat_idx_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign beat_valid = beat_valid_q;
   assign beat_data  = beat_data_q;
   assign beat_idx   = beat_idx_q;
   assign done       = done_q;
   assign err        = err_q;
   assign haddr      = haddr_q;
   assign htrans     = htrans_q;
   assign hburst     = HBURST_C;
   assign hsize      = 3'b010;
   assign hwrite     = 1'b0;

endmodule
